// File: rtl/alu_rs_pkg.sv
// alu_rs_pkg: shared widths, opcodes, entry-state encoding and tag-match helper for the ALU reservation station.
package alu_rs_pkg;
    localparam int DATA_W = 32;
    localparam int TAG_W = 4;
    localparam int RS_W = 3;
    localparam int OP_W = 5;
    localparam logic [TAG_W-1:0] TAG_FREE = '0;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SLT
    } alu_op_e;

    localparam logic [1:0] ST_FREE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;
    localparam logic [1:0] ST_ISSUED = 2'd3;

    // TAG_FREE never matches, so broadcasts of tag 0 are ignored everywhere.
    function automatic logic tag_hit(input logic valid, input logic [TAG_W-1:0] bus_tag,
                                     input logic [TAG_W-1:0] q);
        return valid && bus_tag != TAG_FREE && bus_tag == q;
    endfunction
endpackage

// File: rtl/rs_prio_enc.sv
// rs_prio_enc: lowest-set-bit encoder returning index and a found flag.
module rs_prio_enc #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] req_i,
    output logic [W-1:0] idx_o,
    output logic         found_o
);
    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) idx_o = req_i[i] ? i[W-1:0] : idx_o;
    end
    assign found_o = |req_i;
endmodule

// File: rtl/alu_rs.sv
// alu_rs: ALU reservation station; buffers dispatched ops, snoops ALU/LS CDBs for operands,
// issues the lowest-index ready entry each cycle and frees entries on alu_finish.
module alu_rs
    import alu_rs_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              disp_valid,
    input  logic [OP_W-1:0]   disp_op,
    input  logic [TAG_W-1:0]  disp_qj,
    input  logic [TAG_W-1:0]  disp_qk,
    input  logic [DATA_W-1:0] disp_vj,
    input  logic [DATA_W-1:0] disp_vk,
    input  logic [TAG_W-1:0]  disp_dest,
    output logic              rs_full,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              ls_valid,
    input  logic [TAG_W-1:0]  ls_tag,
    input  logic [DATA_W-1:0] ls_data,
    output logic              issue_valid,
    output logic [OP_W-1:0]   issue_op,
    output logic [DATA_W-1:0] issue_a,
    output logic [DATA_W-1:0] issue_b,
    output logic [TAG_W-1:0]  issue_dest,
    output logic [RS_W-1:0]   issue_rs_num,
    input  logic              alu_finish,
    input  logic [RS_W-1:0]   alu_finish_num
);
    localparam int N = 1 << RS_W;

    logic [1:0]        state_q [N], state_d [N];
    logic [OP_W-1:0]   op_q [N], op_d [N];
    logic [TAG_W-1:0]  qj_q [N], qj_d [N], qk_q [N], qk_d [N], dest_q [N], dest_d [N];
    logic [DATA_W-1:0] vj_q [N], vj_d [N], vk_q [N], vk_d [N];

    logic [N-1:0]    free_vec, ready_vec;
    logic [RS_W-1:0] alloc_idx, sel_idx;
    logic            alloc_found, sel_found, do_disp;
    logic            dj_c, dj_l, dk_c, dk_l;
    logic [DATA_W-1:0] dvj, dvk;
    logic [TAG_W-1:0]  dqj, dqk;

    logic              issue_valid_q;
    logic [OP_W-1:0]   issue_op_q;
    logic [DATA_W-1:0] issue_a_q, issue_b_q;
    logic [TAG_W-1:0]  issue_dest_q;
    logic [RS_W-1:0]   issue_rs_num_q;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            free_vec[i] = state_q[i] == ST_FREE;
            ready_vec[i] = state_q[i] == ST_READY;
        end
    end

    rs_prio_enc #(.N(N), .W(RS_W)) u_alloc (.req_i(free_vec), .idx_o(alloc_idx), .found_o(alloc_found));
    rs_prio_enc #(.N(N), .W(RS_W)) u_sel (.req_i(ready_vec), .idx_o(sel_idx), .found_o(sel_found));

    assign rs_full = !alloc_found;
    assign do_disp = disp_valid && alloc_found;

    // Dispatch bypass: capture a same-cycle broadcast of the operand's producer tag.
    assign dj_c = tag_hit(cdb_valid, cdb_tag, disp_qj);
    assign dj_l = tag_hit(ls_valid, ls_tag, disp_qj);
    assign dk_c = tag_hit(cdb_valid, cdb_tag, disp_qk);
    assign dk_l = tag_hit(ls_valid, ls_tag, disp_qk);
    assign dvj = dj_c ? cdb_data : dj_l ? ls_data : disp_vj;
    assign dvk = dk_c ? cdb_data : dk_l ? ls_data : disp_vk;
    assign dqj = (dj_c || dj_l) ? TAG_FREE : disp_qj;
    assign dqk = (dk_c || dk_l) ? TAG_FREE : disp_qk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            state_d[i] = state_q[i];
            op_d[i] = op_q[i];
            dest_d[i] = dest_q[i];
            qj_d[i] = qj_q[i];
            qk_d[i] = qk_q[i];
            vj_d[i] = vj_q[i];
            vk_d[i] = vk_q[i];
            if (state_q[i] == ST_WAIT) begin
                vj_d[i] = tag_hit(cdb_valid, cdb_tag, qj_q[i]) ? cdb_data :
                          tag_hit(ls_valid, ls_tag, qj_q[i]) ? ls_data : vj_q[i];
                qj_d[i] = (tag_hit(cdb_valid, cdb_tag, qj_q[i]) || tag_hit(ls_valid, ls_tag, qj_q[i]))
                          ? TAG_FREE : qj_q[i];
                vk_d[i] = tag_hit(cdb_valid, cdb_tag, qk_q[i]) ? cdb_data :
                          tag_hit(ls_valid, ls_tag, qk_q[i]) ? ls_data : vk_q[i];
                qk_d[i] = (tag_hit(cdb_valid, cdb_tag, qk_q[i]) || tag_hit(ls_valid, ls_tag, qk_q[i]))
                          ? TAG_FREE : qk_q[i];
                state_d[i] = (qj_d[i] == TAG_FREE && qk_d[i] == TAG_FREE) ? ST_READY : ST_WAIT;
            end
            if (sel_found && sel_idx == i[RS_W-1:0]) state_d[i] = ST_ISSUED;
            if (alu_finish && alu_finish_num == i[RS_W-1:0] && state_q[i] == ST_ISSUED) state_d[i] = ST_FREE;
            if (do_disp && alloc_idx == i[RS_W-1:0]) begin
                op_d[i] = disp_op;
                dest_d[i] = disp_dest;
                vj_d[i] = dvj;
                vk_d[i] = dvk;
                qj_d[i] = dqj;
                qk_d[i] = dqk;
                state_d[i] = (dqj == TAG_FREE && dqk == TAG_FREE) ? ST_READY : ST_WAIT;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                state_q[i] <= ST_FREE;
                op_q[i] <= '0;
                dest_q[i] <= '0;
                qj_q[i] <= '0;
                qk_q[i] <= '0;
                vj_q[i] <= '0;
                vk_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                state_q[i] <= flush ? ST_FREE : state_d[i];
                op_q[i] <= op_d[i];
                dest_q[i] <= dest_d[i];
                qj_q[i] <= qj_d[i];
                qk_q[i] <= qk_d[i];
                vj_q[i] <= vj_d[i];
                vk_q[i] <= vk_d[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            issue_valid_q <= 1'b0;
            issue_op_q <= '0;
            issue_a_q <= '0;
            issue_b_q <= '0;
            issue_dest_q <= '0;
            issue_rs_num_q <= '0;
        end else begin
            issue_valid_q <= sel_found;
            if (sel_found) begin
                issue_op_q <= op_q[sel_idx];
                issue_a_q <= vj_q[sel_idx];
                issue_b_q <= vk_q[sel_idx];
                issue_dest_q <= dest_q[sel_idx];
                issue_rs_num_q <= sel_idx;
            end
        end
    end

    assign issue_valid = issue_valid_q;
    assign issue_op = issue_op_q;
    assign issue_a = issue_a_q;
    assign issue_b = issue_b_q;
    assign issue_dest = issue_dest_q;
    assign issue_rs_num = issue_rs_num_q;

    always @(posedge clk) begin
        if (!rst && !flush && alu_finish)
            assert (state_q[alu_finish_num] == ST_ISSUED)
            else $warning("alu_rs: alu_finish ignored for entry %0d, not issued", alu_finish_num);
    end
endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed spec scenarios plus randomized traffic checked against a behavioural model.
module tb_alu_rs;
    import alu_rs_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, flush, disp_valid, rs_full, cdb_valid, ls_valid, issue_valid, alu_finish;
    logic [OP_W-1:0] disp_op, issue_op;
    logic [TAG_W-1:0] disp_qj, disp_qk, disp_dest, cdb_tag, ls_tag, issue_dest;
    logic [DATA_W-1:0] disp_vj, disp_vk, cdb_data, ls_data, issue_a, issue_b;
    logic [RS_W-1:0] issue_rs_num, alu_finish_num;

    alu_rs dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_op(disp_op), .disp_qj(disp_qj), .disp_qk(disp_qk),
        .disp_vj(disp_vj), .disp_vk(disp_vk), .disp_dest(disp_dest), .rs_full(rs_full),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .ls_valid(ls_valid), .ls_tag(ls_tag), .ls_data(ls_data),
        .issue_valid(issue_valid), .issue_op(issue_op), .issue_a(issue_a), .issue_b(issue_b),
        .issue_dest(issue_dest), .issue_rs_num(issue_rs_num),
        .alu_finish(alu_finish), .alu_finish_num(alu_finish_num)
    );

    int tests = 0;
    int fails = 0;

    // Model: an occupied slot holds an op; it may go to the ALU once both operands are known.
    bit m_busy [8], m_iss [8];
    logic [TAG_W-1:0] m_qj [8], m_qk [8], m_dest [8];
    logic [OP_W-1:0] m_op [8];
    logic [DATA_W-1:0] m_vj [8], m_vk [8];
    logic exp_iv;
    logic [OP_W-1:0] exp_op;
    logic [DATA_W-1:0] exp_a, exp_b;
    logic [TAG_W-1:0] exp_dest;
    logic [RS_W-1:0] exp_num;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit hit(input logic v, input logic [TAG_W-1:0] t, input logic [TAG_W-1:0] q);
        return v && t != 0 && t == q;
    endfunction

    function automatic bit m_full();
        for (int i = 0; i < 8; i++) if (!m_busy[i]) return 0;
        return 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_busy[i] = 0;
            m_iss[i] = 0;
        end
        exp_iv = 0;
        exp_op = 0;
        exp_a = 0;
        exp_b = 0;
        exp_dest = 0;
        exp_num = 0;
    endtask

    task automatic model_step();
        int si = -1;
        int ai = -1;
        if (rst || flush) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 8; i++) begin
            if (si < 0 && m_busy[i] && !m_iss[i] && m_qj[i] == 0 && m_qk[i] == 0) si = i;
            if (ai < 0 && !m_busy[i]) ai = i;
        end
        exp_iv = si >= 0;
        if (alu_finish && m_busy[alu_finish_num] && m_iss[alu_finish_num]) begin
            m_busy[alu_finish_num] = 0;
            m_iss[alu_finish_num] = 0;
        end
        if (si >= 0) begin
            exp_op = m_op[si];
            exp_a = m_vj[si];
            exp_b = m_vk[si];
            exp_dest = m_dest[si];
            exp_num = 3'(si);
            m_iss[si] = 1;
        end
        for (int i = 0; i < 8; i++) begin
            if (m_busy[i] && !m_iss[i]) begin
                if (hit(cdb_valid, cdb_tag, m_qj[i])) begin m_vj[i] = cdb_data; m_qj[i] = 0; end
                else if (hit(ls_valid, ls_tag, m_qj[i])) begin m_vj[i] = ls_data; m_qj[i] = 0; end
                if (hit(cdb_valid, cdb_tag, m_qk[i])) begin m_vk[i] = cdb_data; m_qk[i] = 0; end
                else if (hit(ls_valid, ls_tag, m_qk[i])) begin m_vk[i] = ls_data; m_qk[i] = 0; end
            end
        end
        if (disp_valid && ai >= 0) begin
            m_busy[ai] = 1;
            m_iss[ai] = 0;
            m_op[ai] = disp_op;
            m_dest[ai] = disp_dest;
            m_qj[ai] = disp_qj;
            m_vj[ai] = disp_vj;
            m_qk[ai] = disp_qk;
            m_vk[ai] = disp_vk;
            if (hit(cdb_valid, cdb_tag, disp_qj)) begin m_vj[ai] = cdb_data; m_qj[ai] = 0; end
            else if (hit(ls_valid, ls_tag, disp_qj)) begin m_vj[ai] = ls_data; m_qj[ai] = 0; end
            if (hit(cdb_valid, cdb_tag, disp_qk)) begin m_vk[ai] = cdb_data; m_qk[ai] = 0; end
            else if (hit(ls_valid, ls_tag, disp_qk)) begin m_vk[ai] = ls_data; m_qk[ai] = 0; end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check("m_issue_valid", issue_valid, exp_iv);
        if (exp_iv) begin
            check("m_issue_op", issue_op, exp_op);
            check("m_issue_a", issue_a, exp_a);
            check("m_issue_b", issue_b, exp_b);
            check("m_issue_dest", issue_dest, exp_dest);
            check("m_issue_rs_num", issue_rs_num, exp_num);
        end
        check("m_rs_full", rs_full, m_full());
    endtask

    task automatic idle();
        flush = 0;
        disp_valid = 0;
        disp_op = 0;
        disp_qj = 0;
        disp_qk = 0;
        disp_vj = 0;
        disp_vk = 0;
        disp_dest = 0;
        cdb_valid = 0;
        cdb_tag = 0;
        cdb_data = 0;
        ls_valid = 0;
        ls_tag = 0;
        ls_data = 0;
        alu_finish = 0;
        alu_finish_num = 0;
    endtask

    task automatic disp(input logic [OP_W-1:0] op, input logic [TAG_W-1:0] qj, input logic [DATA_W-1:0] vj,
                        input logic [TAG_W-1:0] qk, input logic [DATA_W-1:0] vk, input logic [TAG_W-1:0] dest);
        disp_valid = 1;
        disp_op = op;
        disp_qj = qj;
        disp_vj = vj;
        disp_qk = qk;
        disp_vk = vk;
        disp_dest = dest;
    endtask

    task automatic finish(input int n);
        alu_finish = 1;
        alu_finish_num = 3'(n);
    endtask

    initial begin
        int cand [$];
        rst = 1;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_issue_valid", issue_valid, 0);
        check("reset_rs_full", rs_full, 0);
        check("reset_issue_a", issue_a, 0);
        rst = 0;

        // 1: ready operands issue at the second edge.
        disp(ALU_ADD, 0, 3, 0, 4, 5);
        cyc();
        idle();
        check("t1_not_yet", issue_valid, 0);
        cyc();
        check("t1_valid", issue_valid, 1);
        check("t1_a", issue_a, 3);
        check("t1_b", issue_b, 4);
        check("t1_dest", issue_dest, 5);
        check("t1_num", issue_rs_num, 0);
        finish(0);
        cyc();
        idle();

        // 2: CDB wakeup.
        disp(ALU_SUB, 7, 0, 0, 2, 6);
        cyc();
        idle();
        cdb_valid = 1; cdb_tag = 7; cdb_data = 32'h10;
        cyc();
        idle();
        check("t2_ready_no_issue", issue_valid, 0);
        cyc();
        check("t2_valid", issue_valid, 1);
        check("t2_a", issue_a, 32'h10);
        check("t2_b", issue_b, 2);
        finish(0);
        cyc();
        idle();

        // 3: LS bypass at dispatch, later CDB wakeup.
        disp(ALU_AND, 2, 0, 9, 0, 1);
        ls_valid = 1; ls_tag = 2; ls_data = 8;
        cyc();
        idle();
        cyc();
        check("t3_waiting", issue_valid, 0);
        cdb_valid = 1; cdb_tag = 9; cdb_data = 1;
        cyc();
        idle();
        cyc();
        check("t3_valid", issue_valid, 1);
        check("t3_a", issue_a, 8);
        check("t3_b", issue_b, 1);
        finish(0);
        cyc();
        idle();

        // 4: fill, drop a dispatch while full, free entry 3 and refill it.
        for (int i = 0; i < 8; i++) begin
            disp(ALU_OR, 0, 100 + i, 0, i, 4'(i));
            cyc();
        end
        check("t4_full", rs_full, 1);
        disp(ALU_OR, 0, 32'hDEAD, 0, 0, 9);
        cyc();
        idle();
        cyc();
        cyc();
        check("t4_still_full", rs_full, 1);
        finish(3);
        cyc();
        idle();
        check("t4_freed", rs_full, 0);
        disp(ALU_XOR, 0, 32'hAA, 0, 1, 12);
        cyc();
        idle();
        cyc();
        check("t4_refill_valid", issue_valid, 1);
        check("t4_refill_num", issue_rs_num, 3);
        check("t4_refill_a", issue_a, 32'hAA);
        flush = 1;
        cyc();
        idle();

        // 5: entries 0,2,5 woken together issue in index order.
        for (int i = 0; i < 6; i++) begin
            disp(ALU_ADD, (i == 0 || i == 2 || i == 5) ? 4'd11 : 4'd12, 0, 0, 0, 4'(i));
            cyc();
        end
        idle();
        cdb_valid = 1; cdb_tag = 11; cdb_data = 32'h55;
        cyc();
        idle();
        check("t5_none", issue_valid, 0);
        cyc();
        check("t5_first_num", issue_rs_num, 0);
        check("t5_first_a", issue_a, 32'h55);
        cyc();
        check("t5_second_num", issue_rs_num, 2);
        cyc();
        check("t5_third_num", issue_rs_num, 5);
        check("t5_third_valid", issue_valid, 1);
        cyc();
        check("t5_no_double", issue_valid, 0);
        flush = 1;
        cyc();
        idle();

        // 6: flush with an issued entry, finish in the same cycle and afterwards; then async reset mid-issue.
        disp(ALU_ADD, 0, 1, 0, 2, 3);
        cyc();
        for (int i = 1; i < 4; i++) begin
            disp(ALU_ADD, 13, 0, 0, 0, 4'(i));
            cyc();
        end
        idle();
        flush = 1;
        finish(0);
        cyc();
        idle();
        check("t6_flush_full", rs_full, 0);
        check("t6_flush_valid", issue_valid, 0);
        finish(0);
        cyc();
        idle();
        check("t6_stale_finish_full", rs_full, 0);
        check("t6_stale_finish_valid", issue_valid, 0);
        disp(ALU_SLT, 0, 32'h77, 0, 32'h88, 4);
        cyc();
        idle();
        cyc();
        check("t6_issue_before_rst", issue_valid, 1);
        check("t6_issue_num", issue_rs_num, 0);
        #2;
        rst = 1;
        #1;
        check("t6_rst_valid", issue_valid, 0);
        check("t6_rst_a", issue_a, 0);
        check("t6_rst_full", rs_full, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            idle();
            disp_valid = 1'($urandom_range(0, 1));
            disp_op = 5'($urandom_range(0, 7));
            disp_qj = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 7)) : 4'd0;
            disp_qk = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 7)) : 4'd0;
            disp_vj = $urandom;
            disp_vk = $urandom;
            disp_dest = 4'($urandom_range(0, 15));
            cdb_valid = 1'($urandom_range(0, 1));
            cdb_tag = 4'($urandom_range(0, 7));
            cdb_data = $urandom;
            ls_valid = 1'($urandom_range(0, 1));
            ls_tag = 4'($urandom_range(0, 7));
            ls_data = $urandom;
            if (cdb_valid && ls_tag == cdb_tag) ls_valid = 0;
            cand.delete();
            for (int i = 0; i < 8; i++) if (m_busy[i] && m_iss[i]) cand.push_back(i);
            if (cand.size() > 0 && $urandom_range(0, 1) == 1) finish(cand[$urandom_range(0, cand.size() - 1)]);
            flush = ($urandom_range(0, 59) == 0);
            cyc();
        end
        idle();
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
